layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  Parametrised pixel compositor and collision monitor for the VGA display path.
//  Takes NUM_LAYERS sprite/tile layers from the per-object *_show modules, each a valid bit plus a colour.
//  Applies a fixed priority plus a flash override and emits one registered RGB pixel.
//  Reports pixel-overlap collisions on NUM_COLL programmable layer-group pairs as pulse-stretched flags and per-frame sticky flags.
// PARAMETERS
//  NUM_LAYERS   12         number of input layers; index 0 = highest priority
//  COLOR_W      24         colour width, {R,G,B}, 8 bits each at default
//  NUM_COLL     2          number of collision channels
//  FLASH_PRIO   1          layers with index < FLASH_PRIO beat flash; range 0..NUM_LAYERS
//  HOLD_CYCLES  416800     collision flag stretch length in clk cycles
//  CNT_W        19         hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES+1
//  BG_COLOR     24'h00FFFF colour shown in the active area when no layer is valid
//  FLASH_COLOR  24'hFFFFFF flash override colour
// PORTS
//  clk          in   1                    pixel clock (25 MHz)
//  rst_n        in   1                    asynchronous active-low reset
//  active       in   1                    h_enable_write & v_enable_write for the current pixel
//  frame_start  in   1                    one-cycle pulse at first pixel of frame; aligned with inputs
//  flash        in   1                    flash override request
//  layer_valid  in   NUM_LAYERS           per-layer pixel valid
//  layer_color  in   NUM_LAYERS*COLOR_W   layer i colour at [i*COLOR_W +: COLOR_W]
//  layer_en     in   NUM_LAYERS           per-layer enable; 0 = ignored for display and collision
//  coll_mask_a  in   NUM_COLL*NUM_LAYERS  channel k group A at [k*NUM_LAYERS +: NUM_LAYERS]
//  coll_mask_b  in   NUM_COLL*NUM_LAYERS  channel k group B, same packing
//  pix_color    out  COLOR_W              composited pixel
//  coll_flag    out  NUM_COLL             stretched collision flag per channel
//  coll_seen    out  NUM_COLL             sticky per-frame collision flag per channel
// BEHAVIOUR
//  Reset: all pipeline registers, pix_color, counters, coll_flag and coll_seen are 0. Async assert, sync release.
//  Pipeline, latency fixed at 2 clk:
//   S1 registers active, frame_start, flash, eff = layer_valid & layer_en, all colours, and hit[k].
//   S2 registers pix_color.
//   Upstream delays h/v sync by 2 to match.
//  hit[k] = active & |(eff & mask_a[k]) & |(eff & mask_b[k]).
//   If a single layer is in both A and B, that layer alone raises the hit; this is legal (self-test use).
//  Colour select in S2, first match wins:
//   1. !active -> 0.
//   2. Lowest index i < FLASH_PRIO with eff[i] -> colour i.
//   3. flash -> FLASH_COLOR.
//   4. Lowest index i with eff[i] -> colour i.
//   5. Otherwise -> BG_COLOR.
//  Hold counter cnt[k], CNT_W bits, driven from S1 hit:
//   - cnt==0 & hit -> 1.
//   - 0 < cnt <= HOLD_CYCLES -> cnt+1.
//   - cnt > HOLD_CYCLES -> 0.
//   - Non-retriggerable: hits while cnt != 0 are ignored.
//   - coll_flag[k] = (cnt[k] != 0), registered; high for exactly HOLD_CYCLES+1 cycles per event.
//   - A hit in the cycle cnt returns to 0 is ignored. The next hit restarts the counter.
//  coll_seen[k]:
//   - Set on S1 hit.
//   - Cleared on S1 frame_start.
//   - frame_start and hit in the same cycle -> set (set wins).
//   - Counts only hits inside the active area.
//  Parameter edge cases: FLASH_PRIO=0 means flash beats every layer; FLASH_PRIO=NUM_LAYERS means flash only beats the background.
//  Reset mid-frame: outputs go to 0 immediately. Stretch in progress is aborted. No pending state survives.
// STRUCTURE
//  Shared package gfx_pkg:
//   - COLOR_W, RGB field localparams.
//   - BG_COLOR and FLASH_COLOR defaults.
//   - Standard layer index constants (LIFE, TITLE, INTRO, SCORE, SHOOTER, PEAS, BRICK, WING, BIRD, PIPE, BG).
//   - Default collision masks (bird-vs-pipe, bird-vs-peas).
//  One sub-module, coll_stretch (params HOLD_CYCLES, CNT_W; ports clk, rst_n, hit, frame_start, flag, seen).
//   - Instantiated NUM_COLL times via generate.
//  Priority select is a for-loop from high index to low inside layer_compositor.
// TESTING
//  Run with NUM_LAYERS=4, NUM_COLL=2, FLASH_PRIO=1, HOLD_CYCLES=10, CNT_W=5.
//  1. Priority: active=1, valid=4'b0110, colours 1:0x112233, 2:0x445566 -> pix_color=0x112233 two cycles later. valid=0 -> 0x00FFFF.
//  2. Flash: flash=1, valid=4'b0011 -> 0x(layer0). valid=4'b0010 -> 0xFFFFFF. active=0 -> 0.
//  3. Enable and blanking: layer_en=4'b1110, valid=4'b0001 -> BG_COLOR. active=0 with any valid -> 0 and no hit.
//  4. Stretch: mask_a[0]=4'b0001, mask_b[0]=4'b0100, one-cycle overlap -> coll_flag[0] high exactly 11 cycles. Second overlap at cycle 5 is ignored. Overlap after return to 0 re-arms.
//  5. Sticky: overlap in frame N sets coll_seen[0]. frame_start clears it. frame_start coincident with overlap leaves it at 1. Channel 1 is unaffected throughout.
//  6. Reset: assert rst_n=0 mid-stretch -> coll_flag, coll_seen, pix_color = 0 asynchronously. After release, no flag until a new overlap.

Source files
------------

// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gfx_pkg
//  Description : Shared graphics constants for the VGA display path: colour
//                layout, default colours, standard layer indices and the
//                default collision group masks.
//  Revision    : 1.0 - initial release
// ============================================================================
package gfx_pkg;

    // Colour layout {R,G,B}, 8 bits per field
    localparam int GFX_COLOR_W    = 24;
    localparam int RED_HI         = 23;
    localparam int RED_LO         = 16;
    localparam int GRN_HI         = 15;
    localparam int GRN_LO         = 8;
    localparam int BLU_HI         = 7;
    localparam int BLU_LO         = 0;

    localparam int GFX_NUM_LAYERS = 12;
    localparam int GFX_NUM_COLL   = 2;

    localparam logic [GFX_COLOR_W-1:0] DEF_BG_COLOR    = 24'h00FFFF;
    localparam logic [GFX_COLOR_W-1:0] DEF_FLASH_COLOR = 24'hFFFFFF;

    // Standard layer indices; index 0 is the highest display priority
    typedef enum logic [3:0] {
        LYR_LIFE    = 4'd0,
        LYR_TITLE   = 4'd1,
        LYR_INTRO   = 4'd2,
        LYR_SCORE   = 4'd3,
        LYR_SHOOTER = 4'd4,
        LYR_PEAS    = 4'd5,
        LYR_BRICK   = 4'd6,
        LYR_WING    = 4'd7,
        LYR_BIRD    = 4'd8,
        LYR_PIPE    = 4'd9,
        LYR_BG      = 4'd10
    } layer_idx_e;

    localparam logic [GFX_NUM_LAYERS-1:0] MASK_BIRD = GFX_NUM_LAYERS'(1) << LYR_BIRD;
    localparam logic [GFX_NUM_LAYERS-1:0] MASK_PIPE = GFX_NUM_LAYERS'(1) << LYR_PIPE;
    localparam logic [GFX_NUM_LAYERS-1:0] MASK_PEAS = GFX_NUM_LAYERS'(1) << LYR_PEAS;

    // Channel 0: bird vs pipe, channel 1: bird vs peas
    localparam logic [GFX_NUM_COLL*GFX_NUM_LAYERS-1:0] DEF_COLL_MASK_A = {MASK_BIRD, MASK_BIRD};
    localparam logic [GFX_NUM_COLL*GFX_NUM_LAYERS-1:0] DEF_COLL_MASK_B = {MASK_PEAS, MASK_PIPE};

    // Pack separate 8-bit fields into one colour word
    function automatic logic [GFX_COLOR_W-1:0] rgb(input logic [7:0] r,
                                                   input logic [7:0] g,
                                                   input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_compositor_if.sv
`default_nettype none
// ============================================================================
//  Module      : layer_compositor_if
//  Description : Layer inputs, collision masks and composited outputs of the
//                layer compositor. master = pixel source, slave = compositor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface layer_compositor_if
    import gfx_pkg::*;
#(
    parameter int NUM_LAYERS = GFX_NUM_LAYERS,
    parameter int COLOR_W    = GFX_COLOR_W,
    parameter int NUM_COLL   = GFX_NUM_COLL
);
    logic                           active;
    logic                           frame_start;
    logic                           flash;
    logic [NUM_LAYERS-1:0]          layer_valid;
    logic [NUM_LAYERS*COLOR_W-1:0]  layer_color;
    logic [NUM_LAYERS-1:0]          layer_en;
    logic [NUM_COLL*NUM_LAYERS-1:0] coll_mask_a;
    logic [NUM_COLL*NUM_LAYERS-1:0] coll_mask_b;
    logic [COLOR_W-1:0]             pix_color;
    logic [NUM_COLL-1:0]            coll_flag;
    logic [NUM_COLL-1:0]            coll_seen;

    modport master (
        output active, frame_start, flash, layer_valid, layer_color, layer_en,
               coll_mask_a, coll_mask_b,
        input  pix_color, coll_flag, coll_seen
    );

    modport slave (
        input  active, frame_start, flash, layer_valid, layer_color, layer_en,
               coll_mask_a, coll_mask_b,
        output pix_color, coll_flag, coll_seen
    );
endinterface
`default_nettype wire

// File: rtl/layer_compositor_coll_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : coll_stretch
//  Description : One collision channel. Stretches a hit into a flag lasting
//                HOLD_CYCLES+1 cycles (non-retriggerable) and keeps a sticky
//                per-frame "seen" flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module coll_stretch #(
    parameter int HOLD_CYCLES = 416800,
    parameter int CNT_W       = 19
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic hit,
    input  wire logic frame_start,
    output logic      flag,
    output logic      seen
);
    localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Counter next state: arm from idle on a hit, run to HOLD+1, then idle
    always_comb begin
        w_cnt_nxt = '0;
        if (r_cnt == '0) begin
            w_cnt_nxt = hit ? CNT_W'(1) : '0;
        end else if (r_cnt <= C_HOLD) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Counter, registered flag and sticky seen (set beats frame clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            flag  <= 1'b0;
            seen  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            flag  <= (r_cnt != '0);
            if (hit) begin
                seen <= 1'b1;
            end else if (frame_start) begin
                seen <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : layer_compositor
//  Description : Priority pixel compositor with flash override and per-channel
//                collision monitor. Two-cycle pixel latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor
    import gfx_pkg::*;
#(
    parameter int                 NUM_LAYERS  = GFX_NUM_LAYERS,
    parameter int                 COLOR_W     = GFX_COLOR_W,
    parameter int                 NUM_COLL    = GFX_NUM_COLL,
    parameter int                 FLASH_PRIO  = 1,
    parameter int                 HOLD_CYCLES = 416800,
    parameter int                 CNT_W       = 19,
    parameter logic [COLOR_W-1:0] BG_COLOR    = COLOR_W'(DEF_BG_COLOR),
    parameter logic [COLOR_W-1:0] FLASH_COLOR = COLOR_W'(DEF_FLASH_COLOR)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    layer_compositor_if.slave  bus
);
    // Stage 1 registers
    logic                          r_active;
    logic                          r_frame_start;
    logic                          r_flash;
    logic [NUM_LAYERS-1:0]         r_eff;
    logic [NUM_LAYERS*COLOR_W-1:0] r_color;
    logic [NUM_COLL-1:0]           r_hit;

    logic [NUM_LAYERS-1:0]         w_eff;
    logic [NUM_COLL-1:0]           w_hit;
    logic [NUM_COLL-1:0]           w_flag;
    logic [NUM_COLL-1:0]           w_seen;

    logic                          w_layer_hit;
    logic [COLOR_W-1:0]            w_layer_color;
    logic                          w_prio_hit;
    logic [COLOR_W-1:0]            w_prio_color;
    logic [COLOR_W-1:0]            w_pix;

    assign w_eff = bus.layer_valid & bus.layer_en;

    // Per-channel hit detection and stretch/sticky logic
    generate
        for (genvar k = 0; k < NUM_COLL; k++) begin : g_coll
            assign w_hit[k] = bus.active
                            & (|(w_eff & bus.coll_mask_a[k*NUM_LAYERS +: NUM_LAYERS]))
                            & (|(w_eff & bus.coll_mask_b[k*NUM_LAYERS +: NUM_LAYERS]));

            coll_stretch #(
                .HOLD_CYCLES (HOLD_CYCLES),
                .CNT_W       (CNT_W)
            ) u_coll_stretch (
                .clk         (clk),
                .rst_n       (rst_n),
                .hit         (r_hit[k]),
                .frame_start (r_frame_start),
                .flag        (w_flag[k]),
                .seen        (w_seen[k])
            );
        end
    endgenerate

    assign bus.coll_flag = w_flag;
    assign bus.coll_seen = w_seen;

    // Stage 1: capture qualified layer state and collision hits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
            r_flash       <= 1'b0;
            r_eff         <= '0;
            r_color       <= '0;
            r_hit         <= '0;
        end else begin
            r_active      <= bus.active;
            r_frame_start <= bus.frame_start;
            r_flash       <= bus.flash;
            r_eff         <= w_eff;
            r_color       <= bus.layer_color;
            r_hit         <= w_hit;
        end
    end

    // Priority select: scan high to low so the lowest valid index lands last
    always_comb begin
        w_layer_hit   = 1'b0;
        w_layer_color = '0;
        w_prio_hit    = 1'b0;
        w_prio_color  = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_eff[i]) begin
                w_layer_hit   = 1'b1;
                w_layer_color = r_color[i*COLOR_W +: COLOR_W];
                if (i < FLASH_PRIO) begin
                    w_prio_hit   = 1'b1;
                    w_prio_color = r_color[i*COLOR_W +: COLOR_W];
                end
            end
        end

        if (!r_active) begin
            w_pix = '0;
        end else if (w_prio_hit) begin
            w_pix = w_prio_color;
        end else if (r_flash) begin
            w_pix = FLASH_COLOR;
        end else if (w_layer_hit) begin
            w_pix = w_layer_color;
        end else begin
            w_pix = BG_COLOR;
        end
    end

    // Stage 2: registered output pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pix_color <= '0;
        end else begin
            bus.pix_color <= w_pix;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_compositor
//  Description : Directed-vector bench for layer_compositor with a cycle-tagged
//                expectation queue checked by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;
    localparam int K_PIX  = 0;
    localparam int K_FLAG = 1;
    localparam int K_SEEN = 2;

    localparam logic [23:0] C0 = 24'hA0B0C0;
    localparam logic [23:0] C1 = 24'h112233;
    localparam logic [23:0] C2 = 24'h445566;
    localparam logic [23:0] C3 = 24'h778899;
    localparam logic [23:0] BG = 24'h00FFFF;
    localparam logic [23:0] FL = 24'hFFFFFF;
    localparam logic [3:0]  OV = 4'b0101;

    typedef struct {
        int          due;
        int          kind;
        int          ch;
        logic [23:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];
    logic [23:0] act;

    layer_compositor_if #(.NUM_LAYERS(4), .COLOR_W(24), .NUM_COLL(2)) bus ();

    layer_compositor #(
        .NUM_LAYERS  (4),
        .COLOR_W     (24),
        .NUM_COLL    (2),
        .FLASH_PRIO  (1),
        .HOLD_CYCLES (10),
        .CNT_W       (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: compare every expectation that falls due this cycle
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                case (q[i].kind)
                    K_PIX:   act = bus.pix_color;
                    K_FLAG:  act = {23'd0, bus.coll_flag[q[i].ch]};
                    default: act = {23'd0, bus.coll_seen[q[i].ch]};
                endcase
                checks++;
                if (q[i].due != cyc || act !== q[i].val) begin
                    errors++;
                    $display("FAIL %s[%0d] cycle %0d (due %0d): got %h expected %h",
                             (q[i].kind == K_PIX) ? "pix_color" :
                             (q[i].kind == K_FLAG) ? "coll_flag" : "coll_seen",
                             q[i].ch, cyc, q[i].due, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    function automatic void expect_v(input int due, input int kind, input int ch,
                                     input logic [23:0] val);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.ch   = ch;
        e.val  = val;
        q.push_back(e);
    endfunction

    task automatic drive(input logic a, input logic fs, input logic fl, input logic [3:0] v);
        bus.active      = a;
        bus.frame_start = fs;
        bus.flash       = fl;
        bus.layer_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all_zero(input int due);
        expect_v(due, K_PIX,  0, 24'h0);
        expect_v(due, K_FLAG, 0, 24'h0);
        expect_v(due, K_FLAG, 1, 24'h0);
        expect_v(due, K_SEEN, 0, 24'h0);
        expect_v(due, K_SEEN, 1, 24'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, p2, r, t;
        logic d_on;
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.active       = 1'b0;
        bus.frame_start  = 1'b0;
        bus.flash        = 1'b0;
        bus.layer_valid  = 4'b0000;
        bus.layer_en     = 4'b1111;
        bus.layer_color  = {C3, C2, C1, C0};
        bus.coll_mask_a  = {4'b1000, 4'b0001};
        bus.coll_mask_b  = {4'b0010, 4'b0100};

        // Reset state
        @(posedge clk); #1;
        expect_all_zero(cyc);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Priority
        expect_v(cyc + 2, K_PIX, 0, C1); drive(1, 0, 0, 4'b0110);
        expect_v(cyc + 2, K_PIX, 0, BG); drive(1, 0, 0, 4'b0000);
        expect_v(cyc + 2, K_PIX, 0, C3); drive(1, 0, 0, 4'b1000);

        // Flash
        expect_v(cyc + 2, K_PIX, 0, C0);    drive(1, 0, 1, 4'b0011);
        expect_v(cyc + 2, K_PIX, 0, FL);    drive(1, 0, 1, 4'b0010);
        expect_v(cyc + 2, K_PIX, 0, 24'h0); drive(0, 0, 1, 4'b0010);
        expect_v(cyc + 2, K_PIX, 0, FL);    drive(1, 0, 1, 4'b0000);

        // Enable masking and blanking
        bus.layer_en = 4'b1110;
        expect_v(cyc + 2, K_PIX, 0, BG); drive(1, 0, 0, 4'b0001);
        bus.layer_en = 4'b1111;
        expect_v(cyc + 2, K_PIX,  0, 24'h0);
        expect_v(cyc + 2, K_SEEN, 0, 24'h0);
        expect_v(cyc + 3, K_FLAG, 0, 24'h0);
        expect_v(cyc + 4, K_FLAG, 0, 24'h0);
        drive(0, 0, 0, OV);
        for (int j = 0; j < 3; j++) drive(1, 0, 0, 4'b0000);

        // Stretch: overlap, ignored retriggers, re-arm after return to 0
        p0 = cyc;
        for (int d = 2; d <= 26; d++) begin
            d_on = ((d >= 3) && (d <= 13)) || ((d >= 15) && (d <= 25));
            expect_v(p0 + d, K_FLAG, 0, {23'd0, d_on});
            expect_v(p0 + d, K_FLAG, 1, 24'h0);
        end
        expect_v(p0 + 2, K_PIX,  0, C0);
        expect_v(p0 + 1, K_SEEN, 0, 24'h0);
        expect_v(p0 + 2, K_SEEN, 0, 24'h1);
        expect_v(p0 + 2, K_SEEN, 1, 24'h0);
        for (int j = 0; j <= 26; j++)
            drive(1, 0, 0, (j == 0 || j == 5 || j == 11 || j == 12) ? OV : 4'b0000);

        // Sticky per-frame flag
        p1 = cyc;
        expect_v(p1 + 1,  K_SEEN, 0, 24'h1);
        expect_v(p1 + 2,  K_SEEN, 0, 24'h0);
        expect_v(p1 + 4,  K_SEEN, 0, 24'h0);
        expect_v(p1 + 5,  K_SEEN, 0, 24'h1);
        expect_v(p1 + 8,  K_SEEN, 0, 24'h1);
        expect_v(p1 + 10, K_SEEN, 0, 24'h1);
        expect_v(p1 + 11, K_SEEN, 0, 24'h0);
        expect_v(p1 + 5,  K_SEEN, 1, 24'h0);
        expect_v(p1 + 8,  K_SEEN, 1, 24'h0);
        expect_v(p1 + 11, K_SEEN, 1, 24'h0);
        for (int j = 0; j <= 12; j++)
            drive(1, (j == 0 || j == 6 || j == 9), 0, (j == 3 || j == 6) ? OV : 4'b0000);
        for (int j = 0; j < 10; j++) drive(1, 0, 0, 4'b0000);

        // Reset mid-stretch
        p2 = cyc;
        expect_v(p2 + 2, K_PIX,  0, C0);
        expect_v(p2 + 3, K_FLAG, 0, 24'h1);
        expect_v(p2 + 4, K_FLAG, 0, 24'h1);
        expect_v(p2 + 4, K_SEEN, 0, 24'h1);
        for (int j = 0; j < 5; j++) drive(1, 0, 0, OV);
        rst_n = 1'b0;
        expect_all_zero(cyc);
        @(posedge clk); #1;
        expect_v(cyc, K_PIX, 0, 24'h0);
        @(posedge clk); #1;
        bus.layer_valid = 4'b0000;
        rst_n = 1'b1;
        r = cyc;
        for (int d = 0; d <= 14; d++) expect_v(r + d, K_FLAG, 0, 24'h0);
        expect_v(r + 2, K_PIX,  0, BG);
        expect_v(r + 3, K_SEEN, 0, 24'h0);
        for (int j = 0; j < 14; j++) drive(1, 0, 0, 4'b0000);
        t = cyc;
        expect_v(t + 2, K_FLAG, 0, 24'h0);
        expect_v(t + 3, K_FLAG, 0, 24'h1);
        drive(1, 0, 0, OV);
        for (int j = 0; j < 4; j++) drive(1, 0, 0, 4'b0000);

        // Every expectation must have been consumed by the monitor
        @(posedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
